// File: rtl/spec_cfa_pkg.sv
// rtl/spec_cfa_pkg.sv - shared sizes and types for speculated-subpath matching
package spec_cfa_pkg;

  localparam int unsigned NUM_PATHS = 4;
  localparam int unsigned MAX_LEN   = 8;

  // One recorded control-flow transfer
  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dest;
  } cfa_entry_t;

  // Subpath length (0..MAX_LEN) and progress counter (0..MAX_LEN-1)
  typedef logic [3:0] path_len_t;
  typedef logic [2:0] prog_t;

  // Lengths beyond the table depth saturate at the table depth
  function automatic path_len_t clamp_len(input path_len_t len);
    return (len > path_len_t'(MAX_LEN)) ? path_len_t'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/spec_path_tracker.sv
// rtl/spec_path_tracker.sv - entry table and progress tracking for one subpath
module spec_path_tracker
  import spec_cfa_pkg::*;
(
  input  logic        clk,
  input  logic        puc_n,
  input  logic        cfg_wen,
  input  logic [2:0]  cfg_idx,
  input  cfa_entry_t  cfg_entry,
  input  logic        cfg_len_wen,
  input  path_len_t   cfg_len,
  input  logic        step,
  input  logic        clear,
  input  cfa_entry_t  cflow_entry,
  input  logic [15:0] cflow_log_ptr,
  output logic        complete,
  output logic        prog_next_nz,
  output logic [15:0] start,
  output logic [15:0] start_next
);

  cfa_entry_t  entries [MAX_LEN];
  path_len_t   len;
  prog_t       prog;
  prog_t       prog_step;
  prog_t       prog_next;
  logic        enabled;
  logic        hit_cur;
  logic        hit_first;

  // A one-entry path would fire on every occurrence of its first transfer, so it is off
  assign enabled   = (len >= 4'd2);
  assign hit_cur   = (entries[prog] == cflow_entry);
  assign hit_first = (entries[0] == cflow_entry);

  // Advance, restart or drop the candidate for this subpath on a logged transfer
  always_comb begin
    prog_step  = prog;
    start_next = start;
    complete   = 1'b0;
    if (step && enabled) begin
      if (hit_cur) begin
        if (({1'b0, prog} + 4'd1) == len) begin
          complete  = 1'b1;
          prog_step = '0;
        end else begin
          prog_step = prog + 3'd1;
        end
        if (prog == '0) begin
          start_next = cflow_log_ptr;
        end
      end else if (hit_first) begin
        prog_step  = 3'd1;
        start_next = cflow_log_ptr;
      end else begin
        prog_step = '0;
      end
    end
    prog_next = clear ? prog_t'(0) : prog_step;
  end

  assign prog_next_nz = (prog_next != '0);

  // Configuration table and length, writable only through the gated strobes
  always_ff @(posedge clk or negedge puc_n) begin
    if (!puc_n) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        entries[i] <= '0;
      end
      len <= '0;
    end else begin
      if (cfg_wen) begin
        entries[cfg_idx] <= cfg_entry;
      end
      if (cfg_len_wen) begin
        len <= clamp_len(cfg_len);
      end
    end
  end

  // Progress counter and candidate start address
  always_ff @(posedge clk or negedge puc_n) begin
    if (!puc_n) begin
      prog  <= '0;
      start <= '0;
    end else begin
      prog  <= prog_next;
      start <= start_next;
    end
  end

endmodule

// File: rtl/spec_path_match.sv
// rtl/spec_path_match.sv - matches logged control flow against speculated subpaths
module spec_path_match
  import spec_cfa_pkg::*;
(
  input  logic        clk,
  input  logic        puc_n,
  input  logic        spec_en,
  input  logic        cfg_wen,
  input  logic [1:0]  cfg_path,
  input  logic [2:0]  cfg_idx,
  input  logic [15:0] cfg_src,
  input  logic [15:0] cfg_dest,
  input  logic        cfg_len_wen,
  input  logic [3:0]  cfg_len,
  input  logic        cflow_hw_wen,
  input  logic [15:0] cflow_log_ptr,
  input  logic [15:0] cflow_src,
  input  logic [15:0] cflow_dest,
  input  logic        flush,
  input  logic        ER_done,
  output logic        detect_active,
  output logic [15:0] active_block_cflog_addr,
  output logic        match_valid,
  output logic [1:0]  match_id
);

  cfa_entry_t             cfg_entry;
  cfa_entry_t             cflow_entry;
  logic                   step;
  logic                   clear;
  logic                   any_complete;
  logic [NUM_PATHS-1:0]   complete_v;
  logic [NUM_PATHS-1:0]   nz_v;
  logic [15:0]            start_v      [NUM_PATHS];
  logic [15:0]            start_next_v [NUM_PATHS];
  logic [1:0]             win_id;
  logic [15:0]            win_addr;
  logic [15:0]            act_addr;

  assign cfg_entry   = '{src: cfg_src, dest: cfg_dest};
  assign cflow_entry = '{src: cflow_src, dest: cflow_dest};

  // Abort sources win over a same-cycle log write, so no step happens then
  assign step         = spec_en & cflow_hw_wen & ~flush & ~ER_done;
  assign any_complete = |complete_v;
  assign clear        = ~spec_en | flush | ER_done | any_complete;

  for (genvar p = 0; p < int'(NUM_PATHS); p++) begin : g_path
    spec_path_tracker u_tracker (
      .clk           (clk),
      .puc_n         (puc_n),
      .cfg_wen       (~spec_en & cfg_wen & (cfg_path == 2'(p))),
      .cfg_idx       (cfg_idx),
      .cfg_entry     (cfg_entry),
      .cfg_len_wen   (~spec_en & cfg_len_wen & (cfg_path == 2'(p))),
      .cfg_len       (cfg_len),
      .step          (step),
      .clear         (clear),
      .cflow_entry   (cflow_entry),
      .cflow_log_ptr (cflow_log_ptr),
      .complete      (complete_v[p]),
      .prog_next_nz  (nz_v[p]),
      .start         (start_v[p]),
      .start_next    (start_next_v[p])
    );
  end

  // Lowest-index completion and lowest-index live candidate
  always_comb begin
    win_id   = '0;
    win_addr = start_v[0];
    act_addr = start_next_v[0];
    for (int p = int'(NUM_PATHS) - 1; p >= 0; p--) begin
      if (complete_v[p]) begin
        win_id   = 2'(p);
        win_addr = start_v[p];
      end
      if (nz_v[p]) begin
        act_addr = start_next_v[p];
      end
    end
  end

  // Registered outputs, one cycle after the logged transfer
  always_ff @(posedge clk or negedge puc_n) begin
    if (!puc_n) begin
      detect_active           <= 1'b0;
      active_block_cflog_addr <= '0;
      match_valid             <= 1'b0;
      match_id                <= '0;
    end else begin
      match_valid   <= any_complete;
      detect_active <= |nz_v;
      if (any_complete) begin
        match_id                <= win_id;
        active_block_cflog_addr <= win_addr;
      end else if (|nz_v) begin
        active_block_cflog_addr <= act_addr;
      end
    end
  end

endmodule

// File: tb/tb_spec_path_match.sv
// tb/tb_spec_path_match.sv - directed self-checking bench for spec_path_match
module tb_spec_path_match;

  logic        clk = 1'b0;
  logic        puc_n = 1'b0;
  logic        spec_en = 1'b0;
  logic        cfg_wen = 1'b0;
  logic [1:0]  cfg_path = '0;
  logic [2:0]  cfg_idx = '0;
  logic [15:0] cfg_src = '0;
  logic [15:0] cfg_dest = '0;
  logic        cfg_len_wen = 1'b0;
  logic [3:0]  cfg_len = '0;
  logic        cflow_hw_wen = 1'b0;
  logic [15:0] cflow_log_ptr = '0;
  logic [15:0] cflow_src = '0;
  logic [15:0] cflow_dest = '0;
  logic        flush = 1'b0;
  logic        ER_done = 1'b0;
  logic        detect_active;
  logic [15:0] active_block_cflog_addr;
  logic        match_valid;
  logic [1:0]  match_id;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        mv;
    logic [1:0]  id;
    logic [15:0] addr;
    logic        da;
  } exp_t;

  exp_t sb[$];

  spec_path_match dut (
    .clk                     (clk),
    .puc_n                   (puc_n),
    .spec_en                 (spec_en),
    .cfg_wen                 (cfg_wen),
    .cfg_path                (cfg_path),
    .cfg_idx                 (cfg_idx),
    .cfg_src                 (cfg_src),
    .cfg_dest                (cfg_dest),
    .cfg_len_wen             (cfg_len_wen),
    .cfg_len                 (cfg_len),
    .cflow_hw_wen            (cflow_hw_wen),
    .cflow_log_ptr           (cflow_log_ptr),
    .cflow_src               (cflow_src),
    .cflow_dest              (cflow_dest),
    .flush                   (flush),
    .ER_done                 (ER_done),
    .detect_active           (detect_active),
    .active_block_cflog_addr (active_block_cflog_addr),
    .match_valid             (match_valid),
    .match_id                (match_id)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cfg_entry_wr(input logic [1:0] p, input logic [2:0] i,
                              input logic [15:0] s, input logic [15:0] d);
    @(negedge clk);
    cfg_wen = 1'b1; cfg_path = p; cfg_idx = i; cfg_src = s; cfg_dest = d;
    @(negedge clk);
    cfg_wen = 1'b0;
  endtask

  task automatic cfg_len_wr(input logic [1:0] p, input logic [3:0] l);
    @(negedge clk);
    cfg_len_wen = 1'b1; cfg_path = p; cfg_len = l;
    @(negedge clk);
    cfg_len_wen = 1'b0;
  endtask

  // One cycle of stimulus; the expected outputs are queued and checked after the edge
  task automatic step(input string tag, input logic wen, input logic [15:0] s,
                      input logic [15:0] d, input logic [15:0] ptr,
                      input logic fl, input logic er,
                      input logic e_mv, input logic [1:0] e_id,
                      input logic [15:0] e_addr, input logic e_da);
    exp_t e;
    @(negedge clk);
    cflow_hw_wen = wen; cflow_src = s; cflow_dest = d; cflow_log_ptr = ptr;
    flush = fl; ER_done = er;
    e.mv = e_mv; e.id = e_id; e.addr = e_addr; e.da = e_da;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cflow_hw_wen = 1'b0; flush = 1'b0; ER_done = 1'b0;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_mv"}, 16'(match_valid), 16'(e.mv));
      chk({tag, "_da"}, 16'(detect_active), 16'(e.da));
      chk({tag, "_addr"}, active_block_cflog_addr, e.addr);
      if (e.mv) chk({tag, "_id"}, 16'(match_id), 16'(e.id));
    end
  endtask

  task automatic cfg_path0;
    cfg_entry_wr(2'd0, 3'd0, 16'hE000, 16'hE010);
    cfg_entry_wr(2'd0, 3'd1, 16'hE014, 16'hE020);
    cfg_entry_wr(2'd0, 3'd2, 16'hE024, 16'hE000);
    cfg_len_wr(2'd0, 4'd3);
  endtask

  initial begin
    #12;
    chk("rst_mv",   16'(match_valid), 16'h0);
    chk("rst_da",   16'(detect_active), 16'h0);
    chk("rst_addr", active_block_cflog_addr, 16'h0);
    chk("rst_id",   16'(match_id), 16'h0);
    @(negedge clk);
    puc_n = 1'b1;

    cfg_path0();
    @(negedge clk); spec_en = 1'b1;

    // Full path0 match
    step("p0a", 1, 16'hE000, 16'hE010, 16'h0140, 0, 0, 0, 0, 16'h0140, 1);
    step("p0b", 1, 16'hE014, 16'hE020, 16'h0142, 0, 0, 0, 0, 16'h0140, 1);
    step("p0c", 1, 16'hE024, 16'hE000, 16'h0144, 0, 0, 1, 0, 16'h0140, 0);
    step("p0idle", 0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 16'h0140, 0);

    // Mismatch drops the candidate, then a fresh full path
    step("mm1", 1, 16'hE000, 16'hE010, 16'h0148, 0, 0, 0, 0, 16'h0148, 1);
    step("mm2", 1, 16'h1234, 16'h5678, 16'h014A, 0, 0, 0, 0, 16'h0148, 0);
    step("mm3", 1, 16'hE000, 16'hE010, 16'h0150, 0, 0, 0, 0, 16'h0150, 1);
    step("mm4", 1, 16'hE014, 16'hE020, 16'h0152, 0, 0, 0, 0, 16'h0150, 1);
    step("mm5", 1, 16'hE024, 16'hE000, 16'h0154, 0, 0, 1, 0, 16'h0150, 0);

    // Paths 1 and 3 identical, path 2 length 1 (disabled)
    @(negedge clk); spec_en = 1'b0;
    cfg_entry_wr(2'd1, 3'd0, 16'hA000, 16'hA004);
    cfg_entry_wr(2'd1, 3'd1, 16'hA008, 16'hA00C);
    cfg_len_wr(2'd1, 4'd2);
    cfg_entry_wr(2'd3, 3'd0, 16'hA000, 16'hA004);
    cfg_entry_wr(2'd3, 3'd1, 16'hA008, 16'hA00C);
    cfg_len_wr(2'd3, 4'd2);
    cfg_entry_wr(2'd2, 3'd0, 16'hB000, 16'hB004);
    cfg_len_wr(2'd2, 4'd1);
    @(negedge clk); spec_en = 1'b1;
    step("dup1", 1, 16'hA000, 16'hA004, 16'h0160, 0, 0, 0, 0, 16'h0160, 1);
    step("dup2", 1, 16'hA008, 16'hA00C, 16'h0162, 0, 0, 1, 1, 16'h0160, 0);
    step("len1", 1, 16'hB000, 16'hB004, 16'h0164, 0, 0, 0, 0, 16'h0160, 0);

    // Partial match aborted by flush, then by ER_done
    step("fl1", 1, 16'hE000, 16'hE010, 16'h0170, 0, 0, 0, 0, 16'h0170, 1);
    step("fl2", 1, 16'hE014, 16'hE020, 16'h0172, 0, 0, 0, 0, 16'h0170, 1);
    step("fl3", 0, 16'h0,    16'h0,    16'h0,    1, 0, 0, 0, 16'h0170, 0);
    step("fl4", 1, 16'hE024, 16'hE000, 16'h0174, 0, 0, 0, 0, 16'h0170, 0);
    step("er1", 1, 16'hE000, 16'hE010, 16'h0176, 0, 0, 0, 0, 16'h0176, 1);
    step("er2", 1, 16'hE014, 16'hE020, 16'h0178, 0, 1, 0, 0, 16'h0176, 0);

    // Matching disabled: log writes are ignored
    @(negedge clk); spec_en = 1'b0;
    step("dis", 1, 16'hE000, 16'hE010, 16'h017A, 0, 0, 0, 0, 16'h0176, 0);

    // Config write while enabled must be ignored
    @(negedge clk); spec_en = 1'b1;
    cfg_entry_wr(2'd0, 3'd0, 16'hDEAD, 16'hBEEF);
    step("lk1", 1, 16'hE000, 16'hE010, 16'h0180, 0, 0, 0, 0, 16'h0180, 1);
    step("lk2", 1, 16'hE014, 16'hE020, 16'h0182, 0, 0, 0, 0, 16'h0180, 1);
    step("lk3", 1, 16'hE024, 16'hE000, 16'h0184, 0, 0, 1, 0, 16'h0180, 0);

    // Reset mid-candidate
    step("rs1", 1, 16'hE000, 16'hE010, 16'h0190, 0, 0, 0, 0, 16'h0190, 1);
    #2;
    puc_n = 1'b0;
    #1;
    chk("arst_da",   16'(detect_active), 16'h0);
    chk("arst_addr", active_block_cflog_addr, 16'h0);
    chk("arst_mv",   16'(match_valid), 16'h0);
    chk("arst_id",   16'(match_id), 16'h0);
    @(negedge clk);
    puc_n = 1'b1;
    step("rs2", 1, 16'hE014, 16'hE020, 16'h0192, 0, 0, 0, 0, 16'h0000, 0);
    step("rs3", 1, 16'hE000, 16'hE010, 16'h0194, 0, 0, 0, 0, 16'h0000, 0);
    step("rs4", 1, 16'hE014, 16'hE020, 16'h0196, 0, 0, 0, 0, 16'h0000, 0);
    step("rs5", 1, 16'hE024, 16'hE000, 16'h0198, 0, 0, 0, 0, 16'h0000, 0);

    chk("sb_empty", 16'(sb.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
